// File: rtl/bt_frame_pkg.sv
// rtl/bt_frame_pkg.sv - shared constants, state encoding and error codes for the Bluetooth frame parser
package bt_frame_pkg;

    localparam logic [7:0] BT_HDR  = 8'hA5;
    localparam logic [7:0] BT_TAIL = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        SUM,
        TAIL
    } bt_state_t;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_LENGTH   = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TAIL     = 2'd3;

endpackage

// File: rtl/bt_frame_timeout.sv
// rtl/bt_frame_timeout.sv - inter-byte gap timer; counts while run is high, cleared by clr
module bt_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Expiry is flagged one count early so the registered error strobe lands
    // TIMEOUT_CYCLES cycles after the last byte strobe.
    localparam logic [CNT_W-1:0] FLAG_AT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count;

    assign expired = run && (count == FLAG_AT);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (clr || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bluetooth_frame_parser.sv
// rtl/bluetooth_frame_parser.sv - assembles A5/cmd/len/payload/sum/5A frames from the UART byte stream
// Optional inter-byte timeout is built when BT_FRAME_TIMEOUT_EN is defined.
module bluetooth_frame_parser
    import bt_frame_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [7:0]               data_byte,
    input  logic                     Rx_Done,
    output logic                     frame_valid,
    output logic [7:0]               cmd,
    output logic [3:0]               payload_len,
    output logic [MAX_PAYLOAD*8-1:0] payload,
    output logic                     frame_err,
    output logic [1:0]               err_code
);

    bt_state_t state, state_nxt;

    logic [7:0]               cmd_q;
    logic [3:0]               len_q;
    logic [3:0]               idx;
    logic [7:0]               acc;
    logic [MAX_PAYLOAD*8-1:0] buffer;
    logic [MAX_PAYLOAD*8-1:0] payload_d;

    logic       expired;
    logic       accept;
    logic       reject;
    logic [1:0] reject_code;

`ifdef BT_FRAME_TIMEOUT_EN
    bt_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .Clk    (Clk),
        .Rst    (Rst),
        .run    (state != IDLE),
        .clr    (Rx_Done),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Rx_Done) begin
            case (state)
                IDLE: if (data_byte == BT_HDR) state_nxt = CMD;
                CMD:  state_nxt = LEN;
                LEN: begin
                    if (data_byte > 8'(MAX_PAYLOAD)) state_nxt = IDLE;
                    else if (data_byte == 8'h00)     state_nxt = SUM;
                    else                             state_nxt = DATA;
                end
                DATA: if (idx + 4'd1 == len_q) state_nxt = SUM;
                SUM:  state_nxt = (data_byte == acc) ? TAIL : IDLE;
                TAIL: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end else if (expired && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        accept      = 1'b0;
        reject      = 1'b0;
        reject_code = ERR_TIMEOUT;
        if (Rx_Done) begin
            case (state)
                LEN: if (data_byte > 8'(MAX_PAYLOAD)) begin
                    reject      = 1'b1;
                    reject_code = ERR_LENGTH;
                end
                SUM: if (data_byte != acc) begin
                    reject      = 1'b1;
                    reject_code = ERR_CHECKSUM;
                end
                TAIL: begin
                    if (data_byte == BT_TAIL) begin
                        accept = 1'b1;
                    end else begin
                        reject      = 1'b1;
                        reject_code = ERR_TAIL;
                    end
                end
                default: ;
            endcase
        end else if (expired && state != IDLE) begin
            reject      = 1'b1;
            reject_code = ERR_TIMEOUT;
        end
    end

    // Bytes beyond the frame's length may hold stale data from older frames.
    always_comb begin
        payload_d = '0;
        for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
            if (i < int'(len_q)) payload_d[i*8 +: 8] = buffer[i*8 +: 8];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cmd_q  <= '0;
            len_q  <= '0;
            idx    <= '0;
            acc    <= '0;
            buffer <= '0;
        end else if (Rx_Done) begin
            case (state)
                CMD: begin
                    cmd_q <= data_byte;
                    acc   <= data_byte;
                end
                LEN: begin
                    acc   <= acc + data_byte;
                    len_q <= data_byte[3:0];
                    idx   <= '0;
                end
                DATA: begin
                    buffer[idx*8 +: 8] <= data_byte;
                    acc                <= acc + data_byte;
                    idx                <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            cmd         <= '0;
            payload_len <= '0;
            payload     <= '0;
        end else begin
            frame_valid <= accept;
            frame_err   <= reject;
            if (reject) err_code <= reject_code;
            if (accept) begin
                cmd         <= cmd_q;
                payload_len <= len_q;
                payload     <= payload_d;
            end
        end
    end

endmodule

// File: doc/bluetooth_frame_parser.md
# bluetooth_frame_parser

Consumes the byte stream from the Bluetooth UART byte receiver (`data_byte` and the `Rx_Done` strobe) and assembles it into command frames. Frame format:

- header 0xA5
- cmd
- len
- len payload bytes
- checksum
- tail 0x5A

Each well-formed frame is presented as one validated record with a single-cycle strobe. Malformed or stalled frames are discarded and reported with an error code. The block sits between the byte receiver and the application command logic.

## Interface
Parameters:
- MAX_PAYLOAD, 8, maximum accepted payload length in bytes (1..15)
- TIMEOUT_CYCLES, 500000, allowed inter-byte gap in Clk cycles (10 ms at 50 MHz); used only with timeout compiled in

Ports (one clock; reset is asynchronous and active-high):
- Clk  input  1  system clock, 50 MHz
- Rst  input  1  asynchronous, active-high reset
- data_byte  input  8  received byte; valid in the cycle Rx_Done is high
- Rx_Done  input  1  one-cycle strobe, one per received byte
- frame_valid  output  1  one-cycle strobe; frame accepted
- cmd  output  8  command byte of the last accepted frame
- payload_len  output  4  payload length of the last accepted frame
- payload  output  MAX_PAYLOAD*8  payload; byte i at bits [8i+7:8i]; unused bytes zero
- frame_err  output  1  one-cycle strobe; frame discarded
- err_code  output  2  0 timeout, 1 length, 2 checksum, 3 tail; valid with frame_err, held until the next error

## Operation
States and transitions; each transition consumes one Rx_Done:
- IDLE: byte 0xA5 → CMD; any other byte is ignored silently, with no error.
- CMD: store the byte as cmd; checksum accumulator := byte → LEN.
- LEN:
  - byte > MAX_PAYLOAD → error 1, return to IDLE.
  - byte = 0 → SUM.
  - otherwise → DATA, with index := 0.
  - Accumulator += byte in all cases.
- DATA: write the byte into buffer[index]; accumulator += byte; when index = len-1 → SUM.
- SUM: byte ≠ accumulator → error 2, return to IDLE. Otherwise → TAIL.
- TAIL:
  - byte = 0x5A → copy the buffer to payload (unused bytes zero), load cmd and payload_len, pulse frame_valid, return to IDLE.
  - Otherwise → error 3, return to IDLE.

Rules:
- The accumulator is 8 bits; the sum is modulo 256, and carries are dropped.
- After an error, the byte that caused it is not re-examined as a header.
- The output record (cmd, payload_len, payload) changes only on frame_valid. It holds its value through errors and any later partial frames.
- The internal buffer is separate from the payload output, so a partial frame never disturbs payload.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: frame_valid, frame_err, cmd, payload_len, payload and err_code all 0.
  - Internal: buffer, accumulator and timer cleared.
- Latency: frame_valid or frame_err is asserted in the cycle after the Rx_Done of the deciding byte. cmd, payload_len and payload are updated on that same edge.
- Rx_Done is guaranteed to be at least 16 cycles apart, so there is no back-pressure and no input buffering.
- Reset asserted mid-frame: the partial frame is dropped and no strobe is issued.
- Strobes are never high for more than one cycle. frame_valid and frame_err are mutually exclusive.

## Configuration
- BT_FRAME_TIMEOUT_EN defined:
  - The timer counts Clk cycles in every state except IDLE and clears on each Rx_Done.
  - When the count reaches TIMEOUT_CYCLES-1: frame_err pulses with err_code 0, and the state returns to IDLE.
  - If Rx_Done and the timeout occur in the same cycle, Rx_Done wins: the byte is processed and the timer cleared.
- BT_FRAME_TIMEOUT_EN undefined: no timer is built, err_code 0 is never produced, and the parser waits indefinitely for each byte.

## Structure
- Package bt_frame_pkg holds:
  - constants BT_HDR = 8'hA5 and BT_TAIL = 8'h5A;
  - the state enum (IDLE, CMD, LEN, DATA, SUM, TAIL);
  - the error-code constants.
- Sub-module bt_frame_timeout is the inter-byte timer:
  - instantiated only under BT_FRAME_TIMEOUT_EN;
  - ports: Clk, Rst, run, clr, expired;
  - counter width $clog2(TIMEOUT_CYCLES).

## Test plan
- A5 01 02 11 22 36 5A → one frame_valid; cmd 0x01, payload_len 2, payload[15:0] 0x2211, remaining payload bytes 0.
- 33 A5 07 00 07 5A → leading 0x33 ignored; frame_valid with cmd 0x07, payload_len 0.
- A5 01 02 11 22 37 5A → frame_err with err_code 2 after the 0x37; no frame_valid; previous record unchanged.
- A5 01 09 (MAX_PAYLOAD=8) → frame_err with err_code 1 after the 0x09; the next A5 frame is parsed normally.
- A5 01 02 11 22 36 5B → frame_err with err_code 3.
- BT_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: A5 01 then silence → frame_err with err_code 0 exactly 100 cycles after the second Rx_Done. Reset pulsed mid-frame → no strobe, and a new full frame is accepted afterwards.
